// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants plus opclass, alu_op and immediate-format encodings.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        OPCLASS_ALU    = 3'd0,
        OPCLASS_ALUI   = 3'd1,
        OPCLASS_LOAD   = 3'd2,
        OPCLASS_STORE  = 3'd3,
        OPCLASS_BRANCH = 3'd4,
        OPCLASS_JAL    = 3'd5,
        OPCLASS_JALR   = 3'd6,
        OPCLASS_UPPER  = 3'd7
    } opclass_e;

    // Branch compares reuse SLT/SLTU; LUI uses PASSB so execute forwards the immediate.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_SEQ   = 4'd10,
        ALU_SNE   = 4'd11,
        ALU_SGE   = 4'd12,
        ALU_SGEU  = 4'd13,
        ALU_PASSB = 4'd14
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// rtl/idu_imm_gen.sv - combinational RV32I immediate generator: format from opcode, sign-extended immediate.
module idu_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm,
    output imm_fmt_e    o_fmt
);

    logic [6:0] w_opcode;

    assign w_opcode = i_instr[6:0];

    always_comb begin
        o_fmt = FMT_R;
        case (w_opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: o_fmt = FMT_I;
            OPC_STORE:                      o_fmt = FMT_S;
            OPC_BRANCH:                     o_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             o_fmt = FMT_U;
            OPC_JAL:                        o_fmt = FMT_J;
            default:                        o_fmt = FMT_R;
        endcase
    end

    // Unknown opcodes fall into FMT_R, so illegal words carry a zero immediate.
    always_comb begin
        o_imm = 32'd0;
        case (o_fmt)
            FMT_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U:   o_imm = {i_instr[31:12], 12'd0};
            FMT_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/idu.sv
// rtl/idu.sv - RV32I decode stage with kill counter for the 2-deep fetch pipeline.
// Optional decode-time JAL redirect enabled by IDU_JAL_REDIRECT_EN.
module idu
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_location,
    input  logic [31:0] instr_to_dec,
    input  logic        flush_from_exe,
    output logic        flush_from_dec,
    output logic [31:0] flush_addr_dec,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [31:0] dec_imm,
    output logic [2:0]  dec_opclass,
    output logic [3:0]  dec_alu_op,
    output logic        dec_illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm;
    imm_fmt_e    w_fmt;
    opclass_e    w_opclass;
    alu_op_e     w_alu_op;
    logic        w_illegal;
    logic        w_live;
    logic        w_jal_redirect;
    logic [31:0] w_jal_target;
    logic [4:0]  w_rd;

    logic [1:0]  r_kill;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] r_imm;
    opclass_e    r_opclass;
    alu_op_e     r_alu_op;
    logic        r_illegal;

    assign w_opcode = instr_to_dec[6:0];
    assign w_funct3 = instr_to_dec[14:12];
    assign w_funct7 = instr_to_dec[31:25];

    assign rf_rs1_addr = instr_to_dec[19:15];
    assign rf_rs2_addr = instr_to_dec[24:20];

    idu_imm_gen u_imm_gen (
        .i_instr (instr_to_dec),
        .o_imm   (w_imm),
        .o_fmt   (w_fmt)
    );

    always_comb begin
        w_opclass = OPCLASS_ALU;
        w_alu_op  = ALU_ADD;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_opclass = OPCLASS_ALU;
                w_alu_op  = alu_from_funct3(w_funct3, w_funct7[5]);
                if (!((w_funct7 == FUNCT7_BASE) ||
                      ((w_funct7 == FUNCT7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))))
                    w_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                w_opclass = OPCLASS_ALUI;
                w_alu_op  = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                if ((w_funct3 == 3'b001) && (w_funct7 != FUNCT7_BASE))
                    w_illegal = 1'b1;
                if ((w_funct3 == 3'b101) && (w_funct7 != FUNCT7_BASE) && (w_funct7 != FUNCT7_ALT))
                    w_illegal = 1'b1;
            end
            OPC_LOAD: begin
                w_opclass = OPCLASS_LOAD;
                w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
            end
            OPC_STORE: begin
                w_opclass = OPCLASS_STORE;
                w_illegal = w_funct3[2] || (w_funct3 == 3'b011);
            end
            OPC_BRANCH: begin
                w_opclass = OPCLASS_BRANCH;
                case (w_funct3)
                    3'b000:  w_alu_op = ALU_SEQ;
                    3'b001:  w_alu_op = ALU_SNE;
                    3'b100:  w_alu_op = ALU_SLT;
                    3'b101:  w_alu_op = ALU_SGE;
                    3'b110:  w_alu_op = ALU_SLTU;
                    3'b111:  w_alu_op = ALU_SGEU;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_JAL:   w_opclass = OPCLASS_JAL;
            OPC_JALR: begin
                w_opclass = OPCLASS_JALR;
                w_illegal = (w_funct3 != 3'b000);
            end
            OPC_LUI: begin
                w_opclass = OPCLASS_UPPER;
                w_alu_op  = ALU_PASSB;
            end
            OPC_AUIPC: w_opclass = OPCLASS_UPPER;
            default:   w_illegal = 1'b1;
        endcase
    end

    // Stores and branches have no destination; a zero rd keeps execute from writing back.
    assign w_rd = ((w_fmt == FMT_S) || (w_fmt == FMT_B)) ? 5'd0 : instr_to_dec[11:7];

    assign w_live = (r_kill == 2'd0) && !flush_from_exe;

`ifdef IDU_JAL_REDIRECT_EN
    assign w_jal_redirect = rst_n && w_live && (w_opcode == OPC_JAL);
`else
    assign w_jal_redirect = 1'b0;
`endif

    assign w_jal_target   = instr_location + w_imm;
    assign flush_from_dec = w_jal_redirect;
    assign flush_addr_dec = w_jal_redirect ? w_jal_target : 32'd0;

    // The two words already in flight behind a redirect are dropped via the kill counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kill    <= 2'd2;
            r_valid   <= 1'b0;
            r_pc      <= 32'd0;
            r_rd      <= 5'd0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_imm     <= 32'd0;
            r_opclass <= OPCLASS_ALU;
            r_alu_op  <= ALU_ADD;
            r_illegal <= 1'b0;
        end else begin
            if (flush_from_exe || w_jal_redirect)
                r_kill <= 2'd2;
            else if (r_kill != 2'd0)
                r_kill <= r_kill - 2'd1;
            r_valid   <= w_live;
            r_pc      <= instr_location;
            r_rd      <= w_rd;
            r_rs1     <= instr_to_dec[19:15];
            r_rs2     <= instr_to_dec[24:20];
            r_imm     <= w_imm;
            r_opclass <= w_opclass;
            r_alu_op  <= w_alu_op;
            r_illegal <= w_illegal;
        end
    end

    assign dec_valid   = r_valid;
    assign dec_pc      = r_pc;
    assign dec_rd      = r_rd;
    assign dec_rs1     = r_rs1;
    assign dec_rs2     = r_rs2;
    assign dec_imm     = r_imm;
    assign dec_opclass = r_opclass;
    assign dec_alu_op  = r_alu_op;
    assign dec_illegal = r_illegal;

endmodule

// File: tb/tb_idu.sv
// tb/tb_idu.sv - scoreboard bench for idu; redirect expectations follow IDU_JAL_REDIRECT_EN.
module tb_idu;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_location;
    logic [31:0] instr_to_dec;
    logic        flush_from_exe;
    logic        flush_from_dec;
    logic [31:0] flush_addr_dec;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic [2:0]  dec_opclass;
    logic [3:0]  dec_alu_op;
    logic        dec_illegal;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  oc;
        logic [3:0]  alu;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          m_kill  = 2;
    logic        m_flush;
    logic        obs_flush;
    logic [31:0] obs_addr;
    logic [4:0]  obs_rs1a;
    logic [4:0]  obs_rs2a;

    idu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_location (instr_location),
        .instr_to_dec   (instr_to_dec),
        .flush_from_exe (flush_from_exe),
        .flush_from_dec (flush_from_dec),
        .flush_addr_dec (flush_addr_dec),
        .rf_rs1_addr    (rf_rs1_addr),
        .rf_rs2_addr    (rf_rs2_addr),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_rd         (dec_rd),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_imm        (dec_imm),
        .dec_opclass    (dec_opclass),
        .dec_alu_op     (dec_alu_op),
        .dec_illegal    (dec_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [2:0] oc,
                                input logic [3:0] alu, input logic ill);
        exp_t e;
        e.valid = 1'b0;
        e.pc    = 32'd0;
        e.rd    = rd;
        e.rs1   = rs1;
        e.rs2   = rs2;
        e.imm   = imm;
        e.oc    = oc;
        e.alu   = alu;
        e.ill   = ill;
        return e;
    endfunction

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input logic fexe,
                         input exp_t payload);
        exp_t e;
        logic live;
        instr_to_dec   = instr;
        instr_location = pc;
        flush_from_exe = fexe;
        live = (m_kill == 0) && !fexe;
`ifdef IDU_JAL_REDIRECT_EN
        m_flush = live && (instr[6:0] == 7'h6F);
`else
        m_flush = 1'b0;
`endif
        e       = payload;
        e.valid = live;
        e.pc    = pc;
        exp_q.push_back(e);
        #1;
        obs_flush = flush_from_dec;
        obs_addr  = flush_addr_dec;
        obs_rs1a  = rf_rs1_addr;
        obs_rs2a  = rf_rs2_addr;
        m_kill = (fexe || m_flush) ? 2 : ((m_kill != 0) ? m_kill - 1 : 0);
        @(posedge clk);
        #1;
        flush_from_exe = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n          = 1'b0;
        instr_to_dec   = 32'h010000EF;
        instr_location = 32'h100;
        flush_from_exe = 1'b0;
        @(posedge clk);
        #1;
        n_total++; if (dec_valid !== 1'b0) $display("FAIL rst_valid got=%0h exp=0", dec_valid); else n_pass++;
        n_total++; if (dec_imm !== 32'd0) $display("FAIL rst_imm got=%h exp=0", dec_imm); else n_pass++;
        n_total++; if (dec_opclass !== 3'd0) $display("FAIL rst_opclass got=%0d exp=0", dec_opclass); else n_pass++;
        n_total++; if (dec_pc !== 32'd0) $display("FAIL rst_pc got=%h exp=0", dec_pc); else n_pass++;
        n_total++; if (flush_from_dec !== 1'b0) $display("FAIL rst_flush got=%0h exp=0", flush_from_dec); else n_pass++;
        rst_n  = 1'b1;
        m_kill = 2;
        for (int i = 0; i < 4; i++) begin
            apply(32'h00000013, 32'(i * 4), 1'b0, mk(5'd0, 5'd0, 5'd0, 32'd0, 3'd1, 4'd0, 1'b0));
            e = exp_q.pop_front();
            n_total++; if (dec_valid !== e.valid) $display("FAIL rst_stream_valid[%0d] got=%0h exp=%0h", i, dec_valid, e.valid); else n_pass++;
            n_total++; if (dec_opclass !== e.oc) $display("FAIL rst_stream_opclass[%0d] got=%0d exp=%0d", i, dec_opclass, e.oc); else n_pass++;
        end
    endtask

    task automatic test_addi;
        exp_t e;
        apply(32'hFFF00293, 32'h40, 1'b0, mk(5'd5, 5'd0, 5'd31, 32'hFFFFFFFF, 3'd1, 4'd0, 1'b0));
        e = exp_q.pop_front();
        n_total++; if (dec_valid !== e.valid) $display("FAIL addi_valid got=%0h exp=%0h", dec_valid, e.valid); else n_pass++;
        n_total++; if (dec_rd !== e.rd) $display("FAIL addi_rd got=%0d exp=%0d", dec_rd, e.rd); else n_pass++;
        n_total++; if (dec_rs1 !== e.rs1) $display("FAIL addi_rs1 got=%0d exp=%0d", dec_rs1, e.rs1); else n_pass++;
        n_total++; if (dec_imm !== e.imm) $display("FAIL addi_imm got=%h exp=%h", dec_imm, e.imm); else n_pass++;
        n_total++; if (dec_pc !== e.pc) $display("FAIL addi_pc got=%h exp=%h", dec_pc, e.pc); else n_pass++;
        n_total++; if (obs_rs2a !== e.rs2) $display("FAIL addi_rf_rs2 got=%0d exp=%0d", obs_rs2a, e.rs2); else n_pass++;
    endtask

    task automatic test_formats;
        logic [31:0] instrs [8];
        exp_t        pays   [8];
        exp_t        e;
        instrs = '{32'h00512423, 32'hFE208EE3, 32'h123451B7, 32'h003100B3,
                   32'h403100B3, 32'hFF02A203, 32'h004100E7, 32'h40315093};
        pays[0] = mk(5'd0, 5'd2, 5'd5,  32'h00000008, 3'd3, 4'd0,  1'b0);
        pays[1] = mk(5'd0, 5'd1, 5'd2,  32'hFFFFFFFC, 3'd4, 4'd10, 1'b0);
        pays[2] = mk(5'd3, 5'd8, 5'd3,  32'h12345000, 3'd7, 4'd14, 1'b0);
        pays[3] = mk(5'd1, 5'd2, 5'd3,  32'h00000000, 3'd0, 4'd0,  1'b0);
        pays[4] = mk(5'd1, 5'd2, 5'd3,  32'h00000000, 3'd0, 4'd1,  1'b0);
        pays[5] = mk(5'd4, 5'd5, 5'd16, 32'hFFFFFFF0, 3'd2, 4'd0,  1'b0);
        pays[6] = mk(5'd1, 5'd2, 5'd4,  32'h00000004, 3'd6, 4'd0,  1'b0);
        pays[7] = mk(5'd1, 5'd2, 5'd3,  32'h00000403, 3'd1, 4'd7,  1'b0);
        for (int i = 0; i < 8; i++) begin
            apply(instrs[i], 32'h200 + 32'(i * 4), 1'b0, pays[i]);
            e = exp_q.pop_front();
            n_total++; if (obs_rs1a !== e.rs1 || obs_rs2a !== e.rs2) $display("FAIL fmt_rf_addr[%0d] got=%0d/%0d exp=%0d/%0d", i, obs_rs1a, obs_rs2a, e.rs1, e.rs2); else n_pass++;
            n_total++; if (dec_valid !== e.valid) $display("FAIL fmt_valid[%0d] got=%0h exp=%0h", i, dec_valid, e.valid); else n_pass++;
            n_total++; if (dec_imm !== e.imm) $display("FAIL fmt_imm[%0d] got=%h exp=%h", i, dec_imm, e.imm); else n_pass++;
            n_total++; if (dec_opclass !== e.oc) $display("FAIL fmt_opclass[%0d] got=%0d exp=%0d", i, dec_opclass, e.oc); else n_pass++;
            n_total++; if (dec_alu_op !== e.alu) $display("FAIL fmt_alu_op[%0d] got=%0d exp=%0d", i, dec_alu_op, e.alu); else n_pass++;
            n_total++; if (dec_rd !== e.rd || dec_rs1 !== e.rs1 || dec_rs2 !== e.rs2) $display("FAIL fmt_regs[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, dec_rd, dec_rs1, dec_rs2, e.rd, e.rs1, e.rs2); else n_pass++;
            n_total++; if (dec_illegal !== e.ill) $display("FAIL fmt_illegal[%0d] got=%0h exp=%0h", i, dec_illegal, e.ill); else n_pass++;
            n_total++; if (dec_pc !== e.pc) $display("FAIL fmt_pc[%0d] got=%h exp=%h", i, dec_pc, e.pc); else n_pass++;
        end
    endtask

    task automatic test_illegal;
        logic [31:0] instrs [5];
        logic        ills   [5];
        exp_t        e;
        instrs = '{32'hFFFFFFFF, 32'h00000000, 32'h023100B3, 32'h00000010, 32'h00000013};
        ills   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            apply(instrs[i], 32'h300 + 32'(i * 4), 1'b0, mk(5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 4'd0, ills[i]));
            e = exp_q.pop_front();
            n_total++; if (dec_valid !== e.valid) $display("FAIL ill_valid[%0d] got=%0h exp=%0h", i, dec_valid, e.valid); else n_pass++;
            n_total++; if (dec_illegal !== e.ill) $display("FAIL ill_flag[%0d] got=%0h exp=%0h", i, dec_illegal, e.ill); else n_pass++;
        end
    endtask

    task automatic test_jal;
        exp_t e;
        apply(32'h010000EF, 32'h100, 1'b0, mk(5'd1, 5'd0, 5'd16, 32'h10, 3'd5, 4'd0, 1'b0));
        e = exp_q.pop_front();
        n_total++; if (obs_flush !== m_flush) $display("FAIL jal_flush got=%0h exp=%0h", obs_flush, m_flush); else n_pass++;
        n_total++; if (obs_addr !== (m_flush ? 32'h110 : 32'h0)) $display("FAIL jal_addr got=%h exp=%h", obs_addr, m_flush ? 32'h110 : 32'h0); else n_pass++;
        n_total++; if (dec_valid !== 1'b1 || dec_valid !== e.valid) $display("FAIL jal_valid got=%0h exp=1", dec_valid); else n_pass++;
        n_total++; if (dec_rd !== e.rd) $display("FAIL jal_rd got=%0d exp=%0d", dec_rd, e.rd); else n_pass++;
        n_total++; if (dec_opclass !== e.oc || dec_imm !== e.imm) $display("FAIL jal_decode got=%0d/%h exp=%0d/%h", dec_opclass, dec_imm, e.oc, e.imm); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            apply(32'h00000013, 32'h104 + 32'(i * 4), 1'b0, mk(5'd0, 5'd0, 5'd0, 32'd0, 3'd1, 4'd0, 1'b0));
            e = exp_q.pop_front();
            n_total++; if (obs_flush !== 1'b0) $display("FAIL jal_shadow_flush[%0d] got=%0h exp=0", i, obs_flush); else n_pass++;
            n_total++; if (dec_valid !== e.valid) $display("FAIL jal_shadow_valid[%0d] got=%0h exp=%0h", i, dec_valid, e.valid); else n_pass++;
        end
    endtask

    task automatic test_jal_exe_flush;
        exp_t e;
        apply(32'h010000EF, 32'h100, 1'b1, mk(5'd1, 5'd0, 5'd16, 32'h10, 3'd5, 4'd0, 1'b0));
        e = exp_q.pop_front();
        n_total++; if (obs_flush !== 1'b0) $display("FAIL exe_pri_flush got=%0h exp=0", obs_flush); else n_pass++;
        n_total++; if (obs_addr !== 32'h0) $display("FAIL exe_pri_addr got=%h exp=0", obs_addr); else n_pass++;
        n_total++; if (dec_valid !== 1'b0 || e.valid !== 1'b0) $display("FAIL exe_pri_valid got=%0h exp=0", dec_valid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            apply(32'h00000013, 32'h104 + 32'(i * 4), 1'b0, mk(5'd0, 5'd0, 5'd0, 32'd0, 3'd1, 4'd0, 1'b0));
            e = exp_q.pop_front();
            n_total++; if (dec_valid !== e.valid) $display("FAIL exe_pri_shadow[%0d] got=%0h exp=%0h", i, dec_valid, e.valid); else n_pass++;
        end
    endtask

    task automatic test_wrap;
        exp_t e;
        apply(32'h020000EF, 32'hFFFFFFF0, 1'b0, mk(5'd1, 5'd0, 5'd0, 32'h20, 3'd5, 4'd0, 1'b0));
        e = exp_q.pop_front();
        n_total++; if (obs_addr !== (m_flush ? 32'h00000010 : 32'h0)) $display("FAIL wrap_addr got=%h exp=%h", obs_addr, m_flush ? 32'h10 : 32'h0); else n_pass++;
        n_total++; if (dec_imm !== e.imm || dec_pc !== e.pc) $display("FAIL wrap_payload got=%h/%h exp=%h/%h", dec_imm, dec_pc, e.imm, e.pc); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            apply(32'h00000013, 32'h0 + 32'(i * 4), 1'b0, mk(5'd0, 5'd0, 5'd0, 32'd0, 3'd1, 4'd0, 1'b0));
            e = exp_q.pop_front();
            n_total++; if (dec_valid !== e.valid) $display("FAIL wrap_shadow[%0d] got=%0h exp=%0h", i, dec_valid, e.valid); else n_pass++;
        end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        apply(32'h010000EF, 32'h500, 1'b0, mk(5'd1, 5'd0, 5'd16, 32'h10, 3'd5, 4'd0, 1'b0));
        e = exp_q.pop_front();
        n_total++; if (dec_valid !== e.valid) $display("FAIL midrst_jal_valid got=%0h exp=%0h", dec_valid, e.valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (dec_valid !== 1'b0 || flush_from_dec !== 1'b0) $display("FAIL midrst_clear got=%0h/%0h exp=0/0", dec_valid, flush_from_dec); else n_pass++;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_kill = 2;
        for (int i = 0; i < 3; i++) begin
            apply(32'h00000013, 32'h600 + 32'(i * 4), 1'b0, mk(5'd0, 5'd0, 5'd0, 32'd0, 3'd1, 4'd0, 1'b0));
            e = exp_q.pop_front();
            n_total++; if (dec_valid !== e.valid) $display("FAIL midrst_resume[%0d] got=%0h exp=%0h", i, dec_valid, e.valid); else n_pass++;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        instr_to_dec   = 32'd0;
        instr_location = 32'd0;
        flush_from_exe = 1'b0;
        m_flush        = 1'b0;
        test_reset();
        test_addi();
        test_formats();
        test_illegal();
        test_jal();
        test_jal_exe_flush();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
